// File: rtl/hada_div_pkg.sv
// Shared types and helpers for the iterative quot/rem divider.
package hada_div_pkg;

  // Widest operand the helpers below are written for.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Counter width for a WIDTH-step iteration, counting WIDTH-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Low `width` bits set.
  function automatic logic [MaxWidth-1:0] width_mask(input int unsigned width);
    return (width >= MaxWidth) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  // Magnitude of a width-bit value; |minBound| = 2^(width-1) still fits unsigned.
  function automatic logic [MaxWidth-1:0] mag(input logic [MaxWidth-1:0] v,
                                              input int unsigned width,
                                              input logic is_signed);
    logic [MaxWidth-1:0] m;
    m = width_mask(width);
    if (is_signed && v[width-1]) begin
      return (~v + 64'd1) & m;
    end
    return v & m;
  endfunction

  // Two's-complement negate when cond is set, wrapping to width bits.
  function automatic logic [MaxWidth-1:0] neg_if(input logic [MaxWidth-1:0] v,
                                                 input logic cond,
                                                 input int unsigned width);
    logic [MaxWidth-1:0] m;
    m = width_mask(width);
    return cond ? ((~v + 64'd1) & m) : (v & m);
  endfunction

endpackage

// File: rtl/hada_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module hada_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dividend_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  // One extra bit: the shifted partial remainder can reach 2*divisor-1.
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {i_rem, i_dividend_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // Trial subtraction succeeded when the difference is non-negative.
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/hada_quot_rem.sv
// Iterative quotRem / divMod unit: WIDTH restoring steps, then a sign-fixup cycle.
module hada_quot_rem #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             floor_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  import hada_div_pkg::*;

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_floor;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_b_zero;
  logic [63:0]      w_mag_a;
  logic [63:0]      w_mag_b;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
  logic [63:0]      w_q_trunc;
  logic [63:0]      w_r_trunc;
  logic [63:0]      w_b_orig;
  logic             w_do_floor;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = in_valid && in_ready;
  assign w_b_zero = (b == '0);
  assign w_mag_a  = mag(64'(a), WIDTH, SIGNED);
  assign w_mag_b  = mag(64'(b), WIDTH, SIGNED);

  hada_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem         (r_rem),
    .i_dividend_bit(r_dvd[WIDTH-1]),
    .i_divisor     (r_dvs),
    .o_rem         (w_step_rem),
    .o_q_bit       (w_step_q)
  );

  // Sign fixup: truncating result first, then the floor correction. The sign
  // flags are only ever set when SIGNED, so unsigned units pass straight through.
  assign w_q_trunc  = neg_if(64'(r_quo), r_sign_a ^ r_sign_b, WIDTH);
  assign w_r_trunc  = neg_if(64'(r_rem), r_sign_a, WIDTH);
  assign w_b_orig   = neg_if(64'(r_dvs), r_sign_b, WIDTH);
  assign w_do_floor = SIGNED && r_floor && (r_rem != '0) && (r_sign_a != r_sign_b);
  assign w_q_fix    = w_do_floor ? (w_q_trunc[WIDTH-1:0] - WIDTH'(1)) : w_q_trunc[WIDTH-1:0];
  assign w_r_fix    = w_do_floor ? (w_r_trunc[WIDTH-1:0] + w_b_orig[WIDTH-1:0])
                                 : w_r_trunc[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next_state = w_b_zero ? DONE : CALC;
      CALC: if (r_cnt == '0) w_next_state = FIX;
      FIX:  w_next_state = DONE;
      DONE: if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath: operand capture, restoring iteration, fixup and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_floor  <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_dbz    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_b_zero) begin
              r_q   <= '0;
              r_r   <= a;
              r_dbz <= 1'b1;
            end else begin
              r_dvd    <= w_mag_a[WIDTH-1:0];
              r_dvs    <= w_mag_b[WIDTH-1:0];
              r_rem    <= '0;
              r_quo    <= '0;
              r_sign_a <= SIGNED && a[WIDTH-1];
              r_sign_b <= SIGNED && b[WIDTH-1];
              r_floor  <= floor_mode;
              r_cnt    <= CntW'(WIDTH - 1);
            end
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_step_q};
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
        end
        FIX: begin
          r_q <= w_q_fix;
          r_r <= w_r_fix;
        end
        DONE: begin
          if (out_ready) r_dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_hada_quot_rem.sv
// Bench for hada_quot_rem: Int8, Word8 and Int32 instances behind one muxed driver.
module tb_hada_quot_rem;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic [63:0] t_a;
  logic [63:0] t_b;
  logic        t_floor;
  logic        t_in_valid;
  logic        t_out_ready;

  logic        ir0, ov0, dz0, ir1, ov1, dz1, ir2, ov2, dz2;
  logic [7:0]  q0, r0, q1, r1;
  logic [31:0] q2, r2;

  logic        m_in_ready, m_out_valid, m_dbz;
  logic [63:0] m_q, m_r;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  hada_quot_rem #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && (sel == 0)), .in_ready(ir0),
    .a(t_a[7:0]), .b(t_b[7:0]), .floor_mode(t_floor), .out_valid(ov0),
    .out_ready(t_out_ready && (sel == 0)), .q(q0), .r(r0), .div_by_zero(dz0)
  );

  hada_quot_rem #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && (sel == 1)), .in_ready(ir1),
    .a(t_a[7:0]), .b(t_b[7:0]), .floor_mode(t_floor), .out_valid(ov1),
    .out_ready(t_out_ready && (sel == 1)), .q(q1), .r(r1), .div_by_zero(dz1)
  );

  hada_quot_rem #(.WIDTH(32), .SIGNED(1'b1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid && (sel == 2)), .in_ready(ir2),
    .a(t_a[31:0]), .b(t_b[31:0]), .floor_mode(t_floor), .out_valid(ov2),
    .out_ready(t_out_ready && (sel == 2)), .q(q2), .r(r2), .div_by_zero(dz2)
  );

  // Present the selected instance on common observation signals.
  always_comb begin
    m_in_ready  = ir0;
    m_out_valid = ov0;
    m_q         = 64'(q0);
    m_r         = 64'(r0);
    m_dbz       = dz0;
    if (sel == 1) begin
      m_in_ready = ir1; m_out_valid = ov1; m_q = 64'(q1); m_r = 64'(r1); m_dbz = dz1;
    end else if (sel == 2) begin
      m_in_ready = ir2; m_out_valid = ov2; m_q = 64'(q2); m_r = 64'(r2); m_dbz = dz2;
    end
  end

  // Reference model using native signed division (truncates toward zero).
  function automatic exp_t model(input int s, input logic [63:0] a, input logic [63:0] b,
                                 input logic fm);
    exp_t        e;
    int          w;
    bit          sg;
    logic [63:0] mask;
    longint      sa, sbv, qq, rr;
    w    = (s == 2) ? 32 : 8;
    sg   = (s != 1);
    mask = (64'd1 << w) - 64'd1;
    if ((b & mask) == 64'd0) begin
      e.q = 64'd0; e.r = a & mask; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    if (sg) begin
      sa  = $signed(a << (64 - w)) >>> (64 - w);
      sbv = $signed(b << (64 - w)) >>> (64 - w);
    end else begin
      sa  = longint'(a & mask);
      sbv = longint'(b & mask);
    end
    qq = sa / sbv;
    rr = sa % sbv;
    if (sg && fm && (rr != 0) && ((rr < 0) != (sbv < 0))) begin
      qq = qq - 1;
      rr = rr + sbv;
    end
    e.q = 64'(qq) & mask; e.r = 64'(rr) & mask; e.dbz = 1'b0; e.lat = w + 2;
    return e;
  endfunction

  // Drive one request, push its expectation, and wait (bounded) for out_valid.
  task automatic issue(input int s, input logic [63:0] a, input logic [63:0] b, input logic fm,
                       output int lat);
    int guard;
    @(negedge clk);
    sel = s; t_a = a; t_b = b; t_floor = fm; t_in_valid = 1'b1;
    guard = 0;
    while (!m_in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    sb.push_back(model(s, a, b, fm));
    #1 t_in_valid = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 0; t_a = '0; t_b = '0; t_floor = 1'b0;
    t_in_valid = 1'b0; t_out_ready = 1'b0;
    #3;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_q !== 64'd0 || m_r !== 64'd0 ||
          m_dbz !== 1'b0) begin
        n_errors++;
        $display("FAIL reset[%0d]: got rdy=%b vld=%b q=%h r=%h dbz=%b, need 1 0 0 0 0",
                 s, m_in_ready, m_out_valid, m_q, m_r, m_dbz);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signed8();
    longint av[10] = '{-7, -7, 7, -6, -128, -128, -128, 0, -5, 127};
    longint bv[10] = '{2, 2, -2, 3, -1, -1, 7, -5, 0, -128};
    bit     fv[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1};
    exp_t   e;
    int     lat;
    for (int i = 0; i < 10; i++) begin
      issue(0, 64'(av[i]), 64'(bv[i]), fv[i], lat);
      e = sb.pop_front();
      n_checks++;
      if (m_q !== e.q || m_r !== e.r || m_dbz !== e.dbz) begin
        n_errors++;
        $display("FAIL s8_result[%0d]: got q=%h r=%h dbz=%b, need q=%h r=%h dbz=%b",
                 i, m_q, m_r, m_dbz, e.q, e.r, e.dbz);
      end
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL s8_latency[%0d]: got %0d edges, need %0d", i, lat, e.lat);
      end
      take();
    end
  endtask

  task automatic test_unsigned8();
    logic [63:0] av[7] = '{200, 200, 5, 0, 255, 255, 3};
    logic [63:0] bv[7] = '{7, 7, 0, 9, 1, 255, 200};
    bit          fv[7] = '{0, 1, 0, 0, 0, 1, 1};
    exp_t        e;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      issue(1, av[i], bv[i], fv[i], lat);
      e = sb.pop_front();
      n_checks++;
      if (m_q !== e.q || m_r !== e.r || m_dbz !== e.dbz || lat != e.lat) begin
        n_errors++;
        $display("FAIL u8_result[%0d]: got q=%h r=%h dbz=%b lat=%0d, need q=%h r=%h dbz=%b lat=%0d",
                 i, m_q, m_r, m_dbz, lat, e.q, e.r, e.dbz, e.lat);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    longint av[2] = '{-7, -5};
    longint bv[2] = '{2, 0};
    exp_t   e;
    int     lat;
    for (int i = 0; i < 2; i++) begin
      issue(0, 64'(av[i]), 64'(bv[i]), 1'b1, lat);
      e = sb.pop_front();
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL bp_latency[%0d]: got %0d, need %0d", i, lat, e.lat);
      end
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        n_checks++;
        if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_q !== e.q || m_r !== e.r ||
            m_dbz !== e.dbz) begin
          n_errors++;
          $display("FAIL bp_hold[%0d.%0d]: got vld=%b rdy=%b q=%h r=%h dbz=%b, need 1 0 %h %h %b",
                   i, c, m_out_valid, m_in_ready, m_q, m_r, m_dbz, e.q, e.r, e.dbz);
        end
      end
      @(negedge clk);
      t_out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_dbz !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_release[%0d]: got rdy=%b vld=%b dbz=%b, need 1 0 0",
                 i, m_in_ready, m_out_valid, m_dbz);
      end
      t_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    @(negedge clk);
    sel = 2; t_a = 64'(-1000000); t_b = 64'd7; t_floor = 1'b1; t_in_valid = 1'b1;
    @(posedge clk);
    #1 t_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (m_in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_busy: got in_ready=%b, need 0", m_in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_out_valid !== 1'b0 || m_q !== 64'd0 || m_r !== 64'd0 || m_in_ready !== 1'b1 ||
        m_dbz !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got vld=%b q=%h r=%h rdy=%b dbz=%b, need 0 0 0 1 0",
               m_out_valid, m_q, m_r, m_in_ready, m_dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2, 64'(-1000000), 64'd7, 1'b1, lat);
    e = sb.pop_front();
    n_checks++;
    if (m_q !== e.q || m_r !== e.r || lat != e.lat) begin
      n_errors++;
      $display("FAIL mid_after_model: got q=%h r=%h lat=%0d, need q=%h r=%h lat=%0d",
               m_q, m_r, lat, e.q, e.r, e.lat);
    end
    n_checks++;
    if (m_q !== 64'h0000_0000_FFFD_D1F6 || m_r !== 64'd6) begin
      n_errors++;
      $display("FAIL mid_after_const: got q=%h r=%h, need q=fffdd1f6 r=6", m_q, m_r);
    end
    take();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [63:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = 64'($urandom);
      b = (i == 5) ? 64'd0 : 64'($urandom_range(1, 40000));
      if (i[0]) b = 64'(-longint'(b));
      issue(2, a, b, i[1], lat);
      e = sb.pop_front();
      n_checks++;
      if (m_q !== e.q || m_r !== e.r || m_dbz !== e.dbz || lat != e.lat) begin
        n_errors++;
        $display("FAIL b2b[%0d] a=%h b=%h: got q=%h r=%h dbz=%b lat=%0d, need %h %h %b %0d",
                 i, a[31:0], b[31:0], m_q, m_r, m_dbz, lat, e.q, e.r, e.dbz, e.lat);
      end
      take();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed8();
    test_unsigned8();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
